// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream request bus plus the uart_tx start/din/busy/ready_flag link.
// slave is the arbiter's view; master is the view of whoever drives the
// requesters and models the transmitter.
interface uart_tx_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_din;
    logic           tx_busy;
    logic           tx_ready_flag;

    modport slave (
        input  req_valid, req_data, req_last, tx_busy, tx_ready_flag,
        output req_ready, tx_start, tx_din
    );

    modport master (
        output req_valid, req_data, req_last, tx_busy, tx_ready_flag,
        input  req_ready, tx_start, tx_din
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between N byte-stream requesters. Arbitration is
// round-robin per packet: the first byte of a packet locks the transmitter
// to its requester until a byte marked last is taken. A one-byte stage
// register sits in front of uart_tx so the next byte is already waiting
// when the transmitter can accept it.
//
// state | meaning
// IDLE  | no packet in progress; next load is arbitrated round-robin
// LOCK  | owner_id is mid-packet; only its bytes are loaded
module uart_tx_arbiter #(
    parameter int  N            = 4,
    parameter int  LOCK_TIMEOUT = 0,
    localparam int IDW          = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_arbiter_if.slave bus,
    output logic [IDW-1:0]   owner_id,
    output logic             locked,
    output logic             timeout_pulse
);

    localparam int            CW       = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t         state;
    logic           stage_valid;
    logic [7:0]     stage_data;
    logic [IDW-1:0] rr_ptr;
    logic [CW-1:0]  stall_cnt;

    logic           rr_found;
    logic [IDW-1:0] rr_winner;
    logic [IDW:0]   rr_sum;
    logic           load;
    logic [IDW-1:0] load_id;
    logic [7:0]     load_data;
    logic           load_last;
    logic           handoff;
    logic           starved;

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        return (id == IDW'(N - 1)) ? '0 : id + 1'b1;
    endfunction

    assign bus.tx_start = stage_valid;
    assign bus.tx_din   = stage_data;
    assign handoff      = stage_valid && (!bus.tx_busy || bus.tx_ready_flag);
    assign load_data    = bus.req_data[{load_id, 3'b000} +: 8];
    assign load_last    = bus.req_last[load_id];
    assign starved      = (state == LOCK) && !stage_valid && !bus.req_valid[owner_id];

    // Round-robin search: first valid requester at or after rr_ptr, wrapping at N.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = rr_ptr;
        rr_sum    = '0;
        for (int i = 0; i < N; i++) begin
            rr_sum = {1'b0, rr_ptr} + (IDW + 1)'(i);
            if (rr_sum >= (IDW + 1)'(N)) rr_sum = rr_sum - (IDW + 1)'(N);
            if (!rr_found && bus.req_valid[rr_sum[IDW-1:0]]) begin
                rr_found  = 1'b1;
                rr_winner = rr_sum[IDW-1:0];
            end
        end
    end

    // Pick the byte to stage; gated by rst_n so req_ready stays low while held in reset.
    always_comb begin
        load          = 1'b0;
        load_id       = owner_id;
        bus.req_ready = '0;
        if (rst_n && !stage_valid) begin
            if (state == IDLE) begin
                load    = rr_found;
                load_id = rr_winner;
            end else begin
                load = bus.req_valid[owner_id];
            end
        end
        if (load) bus.req_ready[load_id] = 1'b1;
    end

    // Stage register, packet lock FSM, round-robin pointer and stall timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            stage_valid   <= 1'b0;
            stage_data    <= 8'h00;
            rr_ptr        <= '0;
            owner_id      <= '0;
            locked        <= 1'b0;
            timeout_pulse <= 1'b0;
            stall_cnt     <= '0;
        end else begin
            timeout_pulse <= 1'b0;
            if (load) begin
                stage_valid <= 1'b1;
                stage_data  <= load_data;
            end else if (handoff) begin
                stage_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (load) begin
                        owner_id <= load_id;
                        if (load_last) begin
                            rr_ptr <= next_id(load_id);
                        end else begin
                            state  <= LOCK;
                            locked <= 1'b1;
                        end
                    end
                end
                LOCK: begin
                    if (load) begin
                        stall_cnt <= '0;
                        if (load_last) begin
                            state  <= IDLE;
                            locked <= 1'b0;
                            rr_ptr <= next_id(owner_id);
                        end
                    end else if ((LOCK_TIMEOUT > 0) && starved) begin
                        if (stall_cnt == TMO_LAST) begin
                            state         <= IDLE;
                            locked        <= 1'b0;
                            rr_ptr        <= next_id(owner_id);
                            timeout_pulse <= 1'b1;
                            stall_cnt     <= '0;
                        end else begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: per-requester packet drivers, a simple
// uart_tx timing model, a packet-level reference arbiter and a scoreboard
// checked at every transmitter hand-off.
module tb_uart_tx_arbiter;
    localparam int N   = 4;
    localparam int TMO = 50;

    typedef struct {
        logic [7:0] data;
        bit         last;
        int         gap;
    } ent_t;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] owner_id;
    logic       locked;
    logic       timeout_pulse;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N(N)) bus ();

    uart_tx_arbiter #(.N(N), .LOCK_TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .owner_id      (owner_id),
        .locked        (locked),
        .timeout_pulse (timeout_pulse)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   cpb    = 2;
    logic busy_m = 1'b0;
    int   frame_cnt = 0;
    logic rflag;

    ent_t pq [N][$];
    exp_t exp_q [$];
    bit   acc [N];
    bit   started [N];
    int   gap_left [N];

    bit   fair_on = 0;
    int   fair_cnt [N];
    bit   bb_on = 0;
    int   bb_hand = 0;
    int   grants = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // uart_tx model: 10-bit frame of cpb clocks per bit; ready_flag in the last frame cycle.
    assign rflag             = busy_m && (frame_cnt == 0);
    assign bus.tx_busy       = busy_m;
    assign bus.tx_ready_flag = rflag;

    always @(posedge clk) begin
        if (bus.tx_start && (!busy_m || rflag)) begin
            busy_m    <= 1'b1;
            frame_cnt <= 10 * cpb - 1;
        end else if (busy_m) begin
            if (frame_cnt == 0) busy_m <= 1'b0;
            else                frame_cnt <= frame_cnt - 1;
        end
    end

    // Requester drivers: hold each byte valid until taken, after its pre-gap.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < N; k++) begin
            if (acc[k]) begin
                acc[k] = 0;
                started[k] = 0;
                if (pq[k].size() > 0) void'(pq[k].pop_front());
            end
            if (pq[k].size() > 0 && !started[k]) begin
                gap_left[k] = pq[k][0].gap;
                started[k]  = 1;
            end
            if (pq[k].size() > 0 && gap_left[k] == 0) begin
                bus.req_valid[k]         = 1'b1;
                bus.req_data[8*k +: 8]   = pq[k][0].data;
                bus.req_last[k]          = pq[k][0].last;
            end else begin
                bus.req_valid[k]         = 1'b0;
                bus.req_data[8*k +: 8]   = 8'h00;
                bus.req_last[k]          = 1'b0;
                if (pq[k].size() > 0) gap_left[k]--;
            end
        end
    end

    // Reference arbiter: owner = -1 when no packet is open; stage modelled as a full flag.
    int m_owner = -1;
    int m_rr    = 0;
    int m_stall = 0;
    bit m_full  = 0;
    bit m_pulse = 0;

    always @(negedge clk) begin
        int g;
        bit was_full;
        logic [N-1:0] exp_ready;
        g = -1;
        was_full = m_full;
        exp_ready = '0;
        if (!rst_n) begin
            m_owner = -1; m_rr = 0; m_stall = 0; m_full = 0; m_pulse = 0;
        end else begin
            if (!m_full) begin
                if (m_owner < 0) begin
                    for (int i = 0; i < N; i++)
                        if (g < 0 && bus.req_valid[(m_rr + i) % N]) g = (m_rr + i) % N;
                end else if (bus.req_valid[m_owner]) begin
                    g = m_owner;
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
            check("tx_start", 32'(bus.tx_start), 32'(m_full));
            check("locked", 32'(locked), 32'(m_owner >= 0));
            check("timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
            for (int k = 0; k < N; k++) if (bus.req_ready[k]) acc[k] = 1;

            m_pulse = 0;
            if (g >= 0) begin
                exp_q.push_back('{g, bus.req_data[8*g +: 8]});
                grants++;
                m_full  = 1;
                m_stall = 0;
                if (bus.req_last[g]) begin
                    m_owner = -1;
                    m_rr    = (g + 1) % N;
                end else begin
                    m_owner = g;
                end
            end else begin
                if (m_full && (!busy_m || rflag)) m_full = 0;
                if (m_owner >= 0 && !was_full) begin
                    m_stall++;
                    if (m_stall == TMO) begin
                        m_rr    = (m_owner + 1) % N;
                        m_owner = -1;
                        m_stall = 0;
                        m_pulse = 1;
                    end
                end
            end
        end
    end

    // Scoreboard monitor: every hand-off to uart_tx must carry the next expected byte.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bb_on && bb_hand >= 1 && bb_hand < 4) check("bb_busy", 32'(busy_m), 32'd1);
            if (bus.tx_start && (!bus.tx_busy || bus.tx_ready_flag)) begin
                if (exp_q.size() == 0) begin
                    check("handoff_unexpected", 32'(bus.tx_din), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_din", 32'(bus.tx_din), 32'(e.data));
                    check("owner_id", 32'(owner_id), 32'(e.id));
                end
                if (fair_on) fair_cnt[owner_id]++;
                if (bb_on) begin
                    if (bb_hand > 0) check("bb_ready_flag", 32'(rflag), 32'd1);
                    bb_hand++;
                end
            end
        end
    end

    task automatic push(input int k, input logic [7:0] d, input bit last, input int gap);
        pq[k].push_back('{d, last, gap});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check("rst_tx_din", 32'(bus.tx_din), 32'd0);
        check("rst_owner_id", 32'(owner_id), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_timeout_pulse", 32'(timeout_pulse), 32'd0);
        for (int k = 0; k < N; k++) begin
            pq[k].delete();
            acc[k] = 0;
            started[k] = 0;
        end
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    function automatic bit drivers_empty();
        for (int k = 0; k < N; k++) if (pq[k].size() > 0) return 0;
        return 1;
    endfunction

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (n < budget && !(drivers_empty() && exp_q.size() == 0 && !busy_m && !bus.tx_start)) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < budget), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n, t0, t1, base, len;
        for (int k = 0; k < N; k++) begin
            acc[k] = 0; started[k] = 0; gap_left[k] = 0; fair_cnt[k] = 0;
        end
        #2;
        do_reset();

        // single one-byte packet from requester 2, then 0 and 3 together (3 must win: rr=3)
        push(2, 8'hA5, 1, 0);
        wait_idle(500, "single_drain");
        push(0, 8'h0F, 1, 0);
        push(3, 8'h3F, 1, 0);
        wait_idle(500, "rr_after_single_drain");

        // contention: two 3-byte packets starting together after reset
        do_reset();
        for (int b = 0; b < 3; b++) begin
            push(0, 8'h10 + 8'(b), b == 2, 0);
            push(1, 8'h20 + 8'(b), b == 2, 0);
        end
        wait_idle(1000, "contention_drain");

        // round-robin fairness with all requesters streaming single bytes
        do_reset();
        fair_on = 1;
        for (int r = 0; r < 10; r++)
            for (int k = 0; k < N; k++) push(k, 8'($urandom), 1, 0);
        wait_idle(3000, "fair_drain");
        fair_on = 0;
        for (int k = 0; k < N; k++) check("fair_share", 32'(fair_cnt[k]), 32'd10);

        // back-to-back frames at 20 clocks per bit
        cpb = 20;
        bb_on = 1;
        bb_hand = 0;
        for (int b = 0; b < 4; b++) push(0, 8'($urandom), b == 3, 0);
        wait_idle(5000, "bb_drain");
        bb_on = 0;
        check("bb_handoffs", 32'(bb_hand), 32'd4);
        cpb = 2;

        // lock timeout: requester 1 stalls after byte 1, requester 2 waiting
        do_reset();
        push(1, 8'h11, 0, 0);
        push(1, 8'h12, 0, 200);
        push(1, 8'h13, 1, 0);
        push(2, 8'h22, 1, 5);
        n = 0;
        while (n < 100 && !bus.tx_start) begin @(negedge clk); n++; end
        n = 0;
        while (n < 100 && bus.tx_start) begin @(negedge clk); n++; end
        t0 = cyc;
        n = 0;
        while (n < 200 && !timeout_pulse) begin @(negedge clk); n++; end
        t1 = cyc;
        check("timeout_delay", 32'(t1 - t0), 32'd50);
        check("timeout_unlocked", 32'(locked), 32'd0);
        check("timeout_next_winner", 32'(bus.req_ready), 32'b0100);
        wait_idle(1000, "timeout_drain");

        // reset in the middle of a 3-byte packet
        base = grants;
        for (int b = 0; b < 3; b++) push(0, 8'h40 + 8'(b), b == 2, 0);
        n = 0;
        while (n < 500 && grants < base + 2) begin @(negedge clk); n++; end
        check("midreset_reach_byte2", 32'(grants - base), 32'd2);
        @(posedge clk);
        #3;
        do_reset();
        push(3, 8'h3C, 1, 0);
        push(1, 8'h1C, 1, 0);
        wait_idle(1000, "midreset_drain");

        // randomized packets, occasional long stalls to trigger revocation
        for (int k = 0; k < N; k++) begin
            for (int p = 0; p < 25; p++) begin
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++)
                    push(k, 8'($urandom), b == len - 1,
                         ($urandom_range(0, 19) == 0) ? 55 : $urandom_range(0, 6));
            end
        end
        wait_idle(40000, "random_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog actual=running expected=finished cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
